// File: rtl/rf_pkg.sv
// Shared definitions for the 2-read/1-write register file: default geometry
// and clear-engine state encodings.
package rf_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
endpackage

// File: rtl/reg_file_2r1w_if.sv
// Bus bundle between the write-back/operand-fetch stages and the register file.
interface reg_file_2r1w_if
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              we;
  logic [ADDR_W-1:0] wAddr;
  logic [DATA_W-1:0] wData;
  logic              re0;
  logic              re1;
  logic [ADDR_W-1:0] rAddr0;
  logic [ADDR_W-1:0] rAddr1;
  logic [DATA_W-1:0] rData0;
  logic [DATA_W-1:0] rData1;
  logic              rValid0;
  logic              rValid1;
  logic              clr_req;
  logic              busy;

  modport master (
    output we, wAddr, wData, re0, re1, rAddr0, rAddr1, clr_req,
    input  rData0, rData1, rValid0, rValid1, busy
  );

  modport slave (
    input  we, wAddr, wData, re0, re1, rAddr0, rAddr1, clr_req,
    output rData0, rData1, rValid0, rValid1, busy
  );
endinterface

// File: rtl/rf_read_port.sv
// One registered read port: DEPTH:1 mux with write-first bypass of whichever
// write (user or clear engine) lands on the array at the same edge.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] mem_i [2**ADDR_W],
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o
);
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              rvalid_d, rvalid_q;

  always_comb begin
    rvalid_d = re_i;
    rdata_d  = rdata_q;
    if (re_i) begin
      rdata_d = (wr_en_i && (wr_addr_i == raddr_i)) ? wr_data_i : mem_i[raddr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised register file: one write port, two bypassed registered read
// ports, and a sequential bulk-clear engine that owns the write port while busy.
module reg_file_2r1w
  import rf_pkg::*;
#(
  parameter int                DATA_W  = DEF_DATA_W,
  parameter int                ADDR_W  = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input logic            clk,
  input logic            reset_n,
  reg_file_2r1w_if.slave bus
);
  localparam int                DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [0:0]        state_d, state_q;
  logic [ADDR_W-1:0] cnt_d, cnt_q;
  logic              busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign busy = (state_q == ST_CLEAR);

  // While clearing, the engine takes the write port and user writes are dropped.
  always_comb begin
    wr_en   = busy | bus.we;
    wr_addr = busy ? cnt_q : bus.wAddr;
    wr_data = busy ? CLR_VAL : bus.wData;
    mem_d   = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy = busy;

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .re_i      (bus.re0),
    .raddr_i   (bus.rAddr0),
    .mem_i     (mem_q),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rdata_o   (bus.rData0),
    .rvalid_o  (bus.rValid0)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .re_i      (bus.re1),
    .raddr_i   (bus.rAddr1),
    .mem_i     (mem_q),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rdata_o   (bus.rData1),
    .rvalid_o  (bus.rValid1)
  );
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Randomised and directed bench for reg_file_2r1w with a scoreboard fed by an
// array-based reference model of the register file and its clear countdown.
module tb_reg_file_2r1w;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam logic [DATA_W-1:0] CLR = '0;

  typedef struct {
    bit              v0;
    logic [DATA_W-1:0] d0;
    bit              v1;
    logic [DATA_W-1:0] d1;
    bit              busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  reg_file_2r1w_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLR_VAL(CLR)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  bit done = 0;

  // Reference model state
  logic [DATA_W-1:0] model [DEPTH];
  int clr_left = 0;
  int clr_idx  = 0;
  logic [DATA_W-1:0] last0 = '0;
  logic [DATA_W-1:0] last1 = '0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rn, input bit we, input int wa, input logic [DATA_W-1:0] wd,
                       input bit r0, input int a0, input bit r1, input int a1, input bit clr);
    exp_t e;
    @(negedge clk);
    reset_n     = rn;
    bus.we      = we;
    bus.wAddr   = ADDR_W'(wa);
    bus.wData   = wd;
    bus.re0     = r0;
    bus.rAddr0  = ADDR_W'(a0);
    bus.re1     = r1;
    bus.rAddr1  = ADDR_W'(a1);
    bus.clr_req = clr;
    if (!rn) begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      clr_left = 0;
      clr_idx  = 0;
      last0 = '0;
      last1 = '0;
      e.v0 = 0; e.v1 = 0;
    end else begin
      if (clr_left > 0) begin
        model[clr_idx] = CLR;
        clr_idx++;
        clr_left--;
      end else begin
        if (we) model[wa] = wd;
        if (clr) begin
          clr_left = DEPTH;
          clr_idx  = 0;
        end
      end
      e.v0 = r0;
      e.v1 = r1;
      if (r0) last0 = model[a0];
      if (r1) last1 = model[a1];
    end
    e.d0 = last0;
    e.d1 = last1;
    e.busy = (clr_left > 0);
    exp_q.push_back(e);
  endtask

  task automatic idle();
    drive(1, 0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) drive(1, 0, 0, '0, 1, i, 1, DEPTH - 1 - i, 0);
  endtask

  // Monitor: the DUT presents a response every cycle; compare it to the queued expectation.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rValid0", {31'b0, bus.rValid0}, {31'b0, e.v0});
        check("rValid1", {31'b0, bus.rValid1}, {31'b0, e.v1});
        check("rData0", bus.rData0, e.d0);
        check("rData1", bus.rData1, e.d1);
        check("busy", {31'b0, bus.busy}, {31'b0, e.busy});
      end
    end
  end

  initial begin
    reset_n = 0;
    bus.we = 0; bus.wAddr = '0; bus.wData = '0;
    bus.re0 = 0; bus.rAddr0 = '0; bus.re1 = 0; bus.rAddr1 = '0;
    bus.clr_req = 0;

    // Reset, then every address reads zero on both ports
    drive(0, 0, 0, '0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, '0, 0, 0, 0, 0, 0);
    read_all();
    idle();

    // Same-cycle write/read bypass, then port 1 reads it back
    drive(1, 1, 5, 32'hDEADBEEF, 1, 5, 0, 0, 0);
    drive(1, 0, 0, '0, 0, 0, 1, 5, 0);
    drive(1, 1, 3, 32'h0BAD_F00D, 1, 3, 1, 3, 0);
    idle();

    // Fill, clear with a mid-clear read of addr 7 and a dropped write to addr 2
    for (int i = 0; i < DEPTH; i++) drive(1, 1, i, 32'h1000 + i, 0, 0, 0, 0, 0);
    drive(1, 0, 0, '0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, '0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, '0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, '0, 1, 7, 1, 0, 0);
    drive(1, 1, 2, 32'hAAAA5555, 0, 0, 1, 2, 0);
    for (int i = 0; i < 5; i++) idle();
    read_all();

    // Simultaneous clr_req and write: write lands, then gets cleared
    drive(1, 1, 0, 32'h12345678, 1, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) drive(1, 0, 0, '0, 1, i, 1, 0, 0);
    drive(1, 1, 4, 32'h5555_AAAA, 1, 0, 1, 4, 0);
    read_all();

    // Reset in the middle of a clear
    for (int i = 0; i < DEPTH; i++) drive(1, 1, i, 32'h2000 + i, 0, 0, 0, 0, 0);
    drive(1, 0, 0, '0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) idle();
    drive(0, 1, 6, 32'hFFFF_0000, 1, 6, 1, 7, 1);
    idle();
    read_all();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 299) != 0),
            $urandom_range(0, 1),
            $urandom_range(0, DEPTH - 1),
            $urandom,
            ($urandom_range(0, 9) < 7),
            $urandom_range(0, DEPTH - 1),
            ($urandom_range(0, 9) < 7),
            $urandom_range(0, DEPTH - 1),
            ($urandom_range(0, 59) == 0));
    end
    read_all();

    @(posedge clk);
    #2;
    done = 1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Parametrised register file, successor to the fixed 8×32 single-read-port register file: 2**ADDR_W words of DATA_W bits, one synchronous write port, two independent registered read ports with write-first bypass, and a hardware bulk-clear engine. It sits between the datapath's write-back stage and its operand-fetch stage.

## Interface
- DATA_W, 32, word width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W words
- CLR_VAL, 0 (DATA_W bits), value written to every entry by the clear engine
- clk  input  1  single clock, all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- we  input  1  write enable
- wAddr  input  ADDR_W  write address
- wData  input  DATA_W  write data
- re0 / re1  input  1  read enable, port 0 / port 1
- rAddr0 / rAddr1  input  ADDR_W  read address, port 0 / port 1
- rData0 / rData1  output  DATA_W  registered read data
- rValid0 / rValid1  output  1  one-cycle pulse, rData valid
- clr_req  input  1  request bulk clear of all entries
- busy  output  1  clear engine active; user writes dropped

## Operation
- Reset (reset_n=0 at an edge): all DEPTH entries 0, rData0/1=0, rValid0/1=0, busy=0, FSM=IDLE, clear counter 0. Reset overrides everything, including a clear in progress.
- Write: if we=1 and busy=0, mem[wAddr] <= wData. If we=1 while busy=1, the write is silently dropped.
- Read port k: if rek=1 at edge N, rDatak <= value of mem[rAddrk] as seen after edge N's write, i.e. write-first. Bypass rules:
  - Accepted user write to the same address at edge N: return wData.
  - Clear-engine write to the same address at edge N: return CLR_VAL.
  - rValidk=1 for exactly the following cycle.
  - If rek=0: rValidk <= 0 and rDatak holds its previous value.
- Reads are allowed while busy. They return current contents: entries already cleared read CLR_VAL, others read old data.
- Both ports may read the same address in the same cycle. Each port returns identical data.
- Clear FSM, two states:
  - IDLE, busy=0. clr_req=1 at an edge -> CLEAR, cnt <= 0, busy <= 1.
  - CLEAR, busy=1. Each edge: mem[cnt] <= CLR_VAL, cnt <= cnt+1. At the edge with cnt == DEPTH-1, the last write occurs, then -> IDLE, busy <= 0.
  - clr_req while in CLEAR is ignored; requests are not queued.
- Simultaneous clr_req and we in IDLE: the write is accepted at that edge (busy still 0). The clear then overwrites it, so the entry ends at CLR_VAL.
- Counter is ADDR_W bits and wraps naturally. Termination is by comparison against DEPTH-1, not by overflow.

## Timing
- Read latency: 1 cycle, address/enable at edge N -> data and valid at edge N+1.
- Write visible to a read issued in the same cycle (bypass); no read-after-write hazard window.
- busy rises 1 cycle after clr_req is sampled. It stays high for exactly DEPTH cycles, then falls.
- First user write after a clear is accepted at the edge where busy is already 0.
- Throughput: one write plus two reads every cycle when not busy.

## Structure
- Shared package/header rf_pkg: FSM state encodings (ST_IDLE, ST_CLEAR), default DATA_W/ADDR_W values.
- Sub-module rf_read_port:
  - Contents: parametrised DEPTH:1 read mux, the bypass compare, and the rData/rValid output registers with synchronous active-low reset.
  - Instantiated twice.
- Storage array, write logic and clear FSM/counter live in the top module.

## Test plan
- Reset, then read all 8 addresses on both ports -> every rData=0, with rValid pulsing once per read.
- Write 0xDEADBEEF to addr 5 at edge N; re0=1, rAddr0=5 at edge N -> rData0=0xDEADBEEF, rValid0=1 at N+1 (bypass). Port 1 reading addr 5 at N+1 -> same value.
- Fill addr i with 0x1000+i. Pulse clr_req -> busy=1 for exactly 8 cycles. A read of addr 7 in busy cycle 3 returns 0x1007; reading all addresses afterwards returns 0.
- During busy, we=1 to addr 2 with 0xAAAA5555 -> dropped; addr 2 reads 0 after the clear.
- clr_req and we (addr 0, 0x12345678) in the same cycle -> write accepted, then cleared; addr 0 reads 0 at the end.
- reset_n=0 in clear cycle 4 with other entries holding data -> next cycle busy=0, all entries 0, rValid0/1=0.
